r0_ctx: RTL and testbench

Parametrised successor to the CPU state register: a FLAGS-bit status word with per-bit bus writes, per-bit condition updates, sticky (set-only) bits, and a DEPTH-entry context stack for nested interrupt entry/exit. Sits in the P-R3 control path between the ALU/condition logic and the W bus. R0 is saved on interrupt entry and restored on return without microcode round-trips through memory.

---
 rtl/r0_pkg.sv | 30 +++
 rtl/r0_ctx_lifo.sv | 92 +++++++++
 rtl/r0_ctx.sv | 80 ++++++++
 tb/tb_r0_ctx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/r0_pkg.sv
// ============================================================================
// Module : r0_pkg
// Brief  : Shared constants for the R0 status word and its context stack.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package r0_pkg;

    localparam int unsigned R0_FLAGS_DEF  = 16;
    localparam logic [15:0] R0_STICKY_DEF = 16'h2000;

    // Flag indices use the bus convention: index 0 is the MSB of the word.
    localparam int unsigned R0_Z = 0;
    localparam int unsigned R0_M = 1;
    localparam int unsigned R0_V = 2;
    localparam int unsigned R0_C = 3;
    localparam int unsigned R0_L = 4;
    localparam int unsigned R0_E = 5;
    localparam int unsigned R0_G = 6;
    localparam int unsigned R0_Y = 7;
    localparam int unsigned R0_X = 8;

    function automatic logic [15:0] r0_bit(input int unsigned idx);
        return 16'h8000 >> idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/r0_ctx_lifo.sv
// ============================================================================
// Module : r0_ctx_lifo
// Brief  : DEPTH x FLAGS context stack with level counter and request decode.
//          Storage is built only when R0_CTX_STACK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module r0_ctx_lifo #(
    parameter int unsigned FLAGS = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_sys,
    input  logic             zer,
    input  logic             push,
    input  logic             pop,
    input  logic [FLAGS-1:0] din,
    output logic [FLAGS-1:0] dout,
    output logic             pop_ok,
    output logic [LW-1:0]    lvl,
    output logic             empty,
    output logic             full,
    output logic             err
);

    logic r_err;

`ifdef R0_CTX_STACK_EN
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAGS-1:0] r_mem [2**AW];
    logic [LW-1:0]    r_lvl;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_bad;
    logic [AW-1:0]    w_rd_idx;

    always_comb begin
        w_push_ok = push & ~pop & (r_lvl != LW'(DEPTH));
        w_pop_ok  = pop & ~push & (r_lvl != '0);
        w_bad     = (push | pop) & ~w_push_ok & ~w_pop_ok;
        w_rd_idx  = AW'(r_lvl - LW'(1));
    end

    always_ff @(posedge clk_sys) begin
        if (zer) begin
            r_lvl <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_bad;
            if (w_push_ok)
                r_lvl <= r_lvl + LW'(1);
            else if (w_pop_ok)
                r_lvl <= r_lvl - LW'(1);
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk_sys) begin
        if (!zer && w_push_ok)
            r_mem[r_lvl[AW-1:0]] <= din;
    end

    assign dout   = r_mem[w_rd_idx];
    assign pop_ok = w_pop_ok;
    assign lvl    = r_lvl;
    assign empty  = (r_lvl == '0);
    assign full   = (r_lvl == LW'(DEPTH));
`else
    logic w_unused;
    assign w_unused = ^din;

    always_ff @(posedge clk_sys) begin
        if (zer)
            r_err <= 1'b0;
        else
            r_err <= push | pop;
    end

    assign dout   = '0;
    assign pop_ok = 1'b0;
    assign lvl    = '0;
    assign empty  = 1'b1;
    assign full   = 1'b1;
`endif

    assign err = r_err;

endmodule

`default_nettype wire

// File: rtl/r0_ctx.sv
// ============================================================================
// Module : r0_ctx
// Brief  : R0 status word with per-bit bus writes, condition updates, sticky
//          bits and a context stack (enabled by R0_CTX_STACK_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module r0_ctx
    import r0_pkg::*;
#(
    parameter int unsigned      FLAGS  = R0_FLAGS_DEF,
    parameter int unsigned      DEPTH  = 4,
    parameter logic [FLAGS-1:0] STICKY = FLAGS'(R0_STICKY_DEF)
) (
    input  logic                         clk_sys,
    input  logic                         zer,
    input  logic [FLAGS-1:0]             w,
    input  logic [FLAGS-1:0]             w_mask,
    input  logic [FLAGS-1:0]             upd_mask,
    input  logic [FLAGS-1:0]             upd_val,
    input  logic                         push,
    input  logic                         pop,
    output logic [FLAGS-1:0]             r0,
    output logic [$clog2(DEPTH+1)-1:0]   lvl,
    output logic                         empty,
    output logic                         full,
    output logic                         err
);

    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [FLAGS-1:0] r_r0;
    logic [FLAGS-1:0] w_upd;
    logic [FLAGS-1:0] w_r0_nxt;
    logic [FLAGS-1:0] w_top;
    logic             w_pop_ok;

    r0_ctx_lifo #(
        .FLAGS (FLAGS),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_lifo (
        .clk_sys (clk_sys),
        .zer     (zer),
        .push    (push),
        .pop     (pop),
        .din     (r_r0),
        .dout    (w_top),
        .pop_ok  (w_pop_ok),
        .lvl     (lvl),
        .empty   (empty),
        .full    (full),
        .err     (err)
    );

    // Bus write beats condition update; sticky bits can only be set by updates.
    always_comb begin
        w_upd = r_r0;
        for (int i = 0; i < int'(FLAGS); i++) begin
            if (w_mask[i])
                w_upd[i] = w[i];
            else if (upd_mask[i])
                w_upd[i] = upd_val[i] | (STICKY[i] & r_r0[i]);
        end
        w_r0_nxt = w_pop_ok ? w_top : w_upd;
    end

    always_ff @(posedge clk_sys) begin
        if (zer)
            r_r0 <= '0;
        else
            r_r0 <= w_r0_nxt;
    end

    assign r0 = r_r0;

endmodule

`default_nettype wire

// File: tb/tb_r0_ctx.sv
// ============================================================================
// Module : tb_r0_ctx
// Brief  : Directed scoreboard bench for r0_ctx (both stack build options).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_r0_ctx;

    localparam int unsigned FLAGS = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 3;
    localparam logic [15:0] STK   = 16'h2000;

    typedef struct {
        logic [15:0]   r0;
        logic [LW-1:0] lvl;
        logic          empty;
        logic          full;
        logic          err;
    } exp_t;

    logic          clk_sys = 1'b0;
    logic          zer = 1'b1;
    logic [15:0]   w = '0, w_mask = '0, upd_mask = '0, upd_val = '0;
    logic          push = 1'b0, pop = 1'b0;
    logic [15:0]   r0;
    logic [LW-1:0] lvl;
    logic          empty, full, err;

    int total = 0;
    int bad   = 0;

    exp_t        sb_q[$];
    logic [15:0] m_r0 = '0;
    int          m_lvl = 0;
    logic        m_err = 1'b0;
    logic [15:0] m_stk [DEPTH];

    r0_ctx #(.FLAGS(FLAGS), .DEPTH(DEPTH), .STICKY(STK)) dut (
        .clk_sys  (clk_sys),
        .zer      (zer),
        .w        (w),
        .w_mask   (w_mask),
        .upd_mask (upd_mask),
        .upd_val  (upd_val),
        .push     (push),
        .pop      (pop),
        .r0       (r0),
        .lvl      (lvl),
        .empty    (empty),
        .full     (full),
        .err      (err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [15:0] nxt;
        logic        push_ok, pop_ok, rej;
        if (zer) begin
            m_r0 = '0; m_lvl = 0; m_err = 1'b0;
            return;
        end
`ifdef R0_CTX_STACK_EN
        push_ok = push && !pop && m_lvl < int'(DEPTH);
        pop_ok  = pop && !push && m_lvl > 0;
`else
        push_ok = 1'b0;
        pop_ok  = 1'b0;
`endif
        rej = (push || pop) && !push_ok && !pop_ok;
        nxt = m_r0;
        for (int i = 0; i < 16; i++) begin
            if (w_mask[i])        nxt[i] = w[i];
            else if (upd_mask[i]) nxt[i] = STK[i] ? (m_r0[i] | upd_val[i]) : upd_val[i];
        end
        if (push_ok) begin
            m_stk[m_lvl] = m_r0;
            m_lvl++;
        end
        if (pop_ok) begin
            m_lvl--;
            nxt = m_stk[m_lvl];
        end
        m_r0  = nxt;
        m_err = rej;
    endtask

    // One clock: drive at negedge, queue the expectation, compare after posedge.
    task automatic cyc(input logic z, input logic [15:0] wd, input logic [15:0] wm,
                       input logic [15:0] um, input logic [15:0] uv,
                       input logic pu, input logic po);
        exp_t e;
        @(negedge clk_sys);
        zer = z; w = wd; w_mask = wm; upd_mask = um; upd_val = uv; push = pu; pop = po;
        model_step();
        e.r0 = m_r0; e.lvl = LW'(m_lvl); e.empty = (m_lvl == 0); e.err = m_err;
`ifdef R0_CTX_STACK_EN
        e.full = (m_lvl == int'(DEPTH));
`else
        e.full = 1'b1;
`endif
        sb_q.push_back(e);
        @(posedge clk_sys);
        #1;
        e = sb_q.pop_front();
        chk("r0",    32'(r0),    32'(e.r0));
        chk("lvl",   32'(lvl),   32'(e.lvl));
        chk("empty", 32'(empty), 32'(e.empty));
        chk("full",  32'(full),  32'(e.full));
        chk("err",   32'(err),   32'(e.err));
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [15:0] v);
        cyc(1'b0, v, 16'hFFFF, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset values
        cyc(1'b1, '0, '0, '0, '0, 1'b0, 1'b0);
        chk("rst_r0", 32'(r0), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);

        wr(16'hA5C3);
        chk("wr_a5c3", 32'(r0), 32'hA5C3);
        cyc(1'b1, 16'hFFFF, 16'hFFFF, '0, '0, 1'b1, 1'b0);
        chk("rst_over_wr", 32'(r0), 32'h0);
        chk("rst_lvl", 32'(lvl), 32'h0);

        // sticky V bit
        cyc(1'b0, '0, '0, 16'h2000, 16'h2000, 1'b0, 1'b0);
        chk("v_set", 32'(r0), 32'h2000);
        cyc(1'b0, '0, '0, 16'h2000, 16'h0000, 1'b0, 1'b0);
        chk("v_sticky", 32'(r0), 32'h2000);
        cyc(1'b0, 16'h0000, 16'h2000, '0, '0, 1'b0, 1'b0);
        chk("v_bus_clr", 32'(r0), 32'h0);

        // bus write and update on disjoint bits
        cyc(1'b0, 16'h1200, 16'hFF00, 16'h0080, 16'h0080, 1'b0, 1'b0);
        chk("mixed_1280", 32'(r0), 32'h1280);
        cyc(1'b0, 16'h00FF, 16'h0001, 16'h0081, 16'h0000, 1'b0, 1'b0);
        chk("nonsticky_clr", 32'(r0), 32'h1201);

`ifdef R0_CTX_STACK_EN
        cyc(1'b1, '0, '0, '0, '0, 1'b0, 1'b0);
        for (int v = 1; v <= 4; v++) begin
            wr(16'(v));
            cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
        end
        chk("full_at4", 32'(full), 32'h1);
        cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
        chk("ovf_err", 32'(err), 32'h1);
        chk("ovf_lvl", 32'(lvl), 32'h4);
        idle();
        chk("err_drop", 32'(err), 32'h0);
        for (int v = 4; v >= 1; v--) begin
            cyc(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
            chk("pop_val", 32'(r0), 32'(v));
        end
        chk("pop_empty", 32'(empty), 32'h1);
        cyc(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        chk("udf_err", 32'(err), 32'h1);
        chk("udf_r0", 32'(r0), 32'h1);

        wr(16'h0011);
        cyc(1'b0, 16'hBEEF, 16'hFFFF, '0, '0, 1'b1, 1'b0);
        chk("push_wr", 32'(r0), 32'hBEEF);
        cyc(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        chk("pop_0011", 32'(r0), 32'h0011);

        cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0F0F, 16'hFFFF, '0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
        chk("pp_err", 32'(err), 32'h1);
        chk("pp_lvl", 32'(lvl), 32'h2);
        chk("pp_r0", 32'(r0), 32'h0F0F);
`else
        cyc(1'b0, 16'h4321, 16'hFFFF, '0, '0, 1'b1, 1'b0);
        chk("ns_push_err", 32'(err), 32'h1);
        chk("ns_lvl", 32'(lvl), 32'h0);
        chk("ns_full", 32'(full), 32'h1);
        chk("ns_push_wr", 32'(r0), 32'h4321);
        cyc(1'b0, '0, '0, 16'h0100, 16'h0100, 1'b0, 1'b1);
        chk("ns_pop_r0", 32'(r0), 32'h4321);
        idle();
        chk("ns_err_drop", 32'(err), 32'h0);
        cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
        chk("ns_pp_err", 32'(err), 32'h1);
`endif

        // mixed traffic against the model
        for (int k = 0; k < 60; k++) begin
            cyc(($urandom_range(0, 29) == 0), 16'($urandom),
                16'($urandom) & 16'($urandom), 16'($urandom) & 16'($urandom),
                16'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
